// File: rtl/mnist_accel_pkg.sv
// Shared definitions for the Nios II PIO to CNN accelerator bridge:
// FSM states and bit positions inside the PIO command and status words.
package mnist_accel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_t;

  // pio_cmd fields
  localparam int unsigned STROBE_BIT = 16;
  localparam int unsigned CLR_BIT    = 17;
  localparam int unsigned SEL_LSB    = 20;
  localparam int unsigned SEL_W      = 4;

  // pio_status fields
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned BUSY_BIT    = 16;
  localparam int unsigned DONE_BIT    = 17;
  localparam int unsigned OVERRUN_BIT = 18;
  localparam int unsigned TIMEOUT_BIT = 19;

endpackage

// File: rtl/pio_toggle_strobe.sv
// Turns a software-toggled PIO bit into a registered one-cycle event and
// registers the pixel that accompanies it.
module pio_toggle_strobe #(
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             toggle,
  input  logic             clear,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             strobe,
  output logic [PIX_W-1:0] pixel
);

  logic prev;

  // History tracks the toggle even during clear so releasing clear never
  // produces a stale event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 1'b0;
      strobe <= 1'b0;
      pixel  <= '0;
    end else begin
      prev   <= toggle;
      strobe <= (toggle ^ prev) & ~clear;
      pixel  <= pixel_in;
    end
  end

endmodule

// File: rtl/pio_accel_bridge.sv
// Bridge between the Nios II PIO pair and the CNN accelerator: pixel
// strobes and frame counting, result capture and software-visible status.
module pio_accel_bridge
  import mnist_accel_pkg::*;
#(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned RES_W        = 32,
  parameter int unsigned FRAME_PIXELS = 784,
  parameter int unsigned TIMEOUT_CYC  = 4096
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [31:0]             pio_cmd,
  output logic [RES_W-1:0]        pio_result,
  output logic [31:0]             pio_status,
  output logic                    acc_valid,
  output logic [PIX_W-1:0]        acc_pixel,
  output logic                    acc_clr_n,
  input  logic [NUM_CH*RES_W-1:0] acc_result,
  input  logic                    acc_result_valid
);

  localparam int unsigned      TW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_PIXELS);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [TW-1:0]    wait_cnt;
  logic             overrun;
  logic             timeout;
  logic [RES_W-1:0] res_buf [NUM_CH];
  logic [RES_W-1:0] sel_res;
  logic             strobe;
  logic [PIX_W-1:0] strobe_pixel;
  logic             clr;
  logic [SEL_W-1:0] sel;
  logic             unused_cmd;

  assign clr        = pio_cmd[CLR_BIT];
  assign sel        = pio_cmd[SEL_LSB +: SEL_W];
  assign count_nxt  = count + CNT_W'(1);
  // Reserved command bits are ignored by design.
  assign unused_cmd = ^pio_cmd;

  pio_toggle_strobe #(
    .PIX_W (PIX_W)
  ) u_strobe (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .toggle   (pio_cmd[STROBE_BIT]),
    .clear    (clr),
    .pixel_in (pio_cmd[PIX_W-1:0]),
    .strobe   (strobe),
    .pixel    (strobe_pixel)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      wait_cnt  <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      acc_valid <= 1'b0;
      acc_pixel <= '0;
      acc_clr_n <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) res_buf[k] <= '0;
    end else begin
      acc_clr_n <= ~clr;
      acc_valid <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        count    <= '0;
        wait_cnt <= '0;
        overrun  <= 1'b0;
        timeout  <= 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) res_buf[k] <= '0;
      end else begin
        if (strobe) begin
          if (state == IDLE || state == STREAM) begin
            acc_valid <= 1'b1;
            acc_pixel <= strobe_pixel;
            count     <= count_nxt;
            state     <= (count_nxt == FRAME_LAST) ? WAIT_RES : STREAM;
          end else begin
            overrun <= 1'b1;
          end
        end
        if (state == WAIT_RES) begin
          if (acc_result_valid) begin
            for (int unsigned k = 0; k < NUM_CH; k++)
              res_buf[k] <= acc_result[k*RES_W +: RES_W];
            state <= DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    sel_res = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (sel == SEL_W'(k)) sel_res = res_buf[k];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pio_result <= '0;
    else            pio_result <= sel_res;
  end

  always_comb begin
    pio_status              = '0;
    pio_status[CNT_W-1:0]   = count;
    pio_status[BUSY_BIT]    = (state == STREAM) || (state == WAIT_RES);
    pio_status[DONE_BIT]    = (state == DONE);
    pio_status[OVERRUN_BIT] = overrun;
    pio_status[TIMEOUT_BIT] = timeout;
  end

endmodule

// File: tb/tb_pio_accel_bridge.sv
// Self-checking bench for pio_accel_bridge: randomized PIO traffic compared
// every cycle against a frame-level behavioural model, plus literal checks.
module tb_pio_accel_bridge;

  localparam int PIX_W  = 8;
  localparam int NUM_CH = 4;
  localparam int RES_W  = 32;
  localparam int FRAME  = 784;
  localparam int TMO    = 4096;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [31:0]             pio_cmd;
  logic [RES_W-1:0]        pio_result;
  logic [31:0]             pio_status;
  logic                    acc_valid;
  logic [PIX_W-1:0]        acc_pixel;
  logic                    acc_clr_n;
  logic [NUM_CH*RES_W-1:0] acc_result;
  logic                    acc_result_valid;

  always #5 clk = ~clk;

  pio_accel_bridge #(
    .PIX_W        (PIX_W),
    .NUM_CH       (NUM_CH),
    .RES_W        (RES_W),
    .FRAME_PIXELS (FRAME),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .sys_clk          (clk),
    .sys_rst_n        (rst_n),
    .pio_cmd          (pio_cmd),
    .pio_result       (pio_result),
    .pio_status       (pio_status),
    .acc_valid        (acc_valid),
    .acc_pixel        (acc_pixel),
    .acc_clr_n        (acc_clr_n),
    .acc_result       (acc_result),
    .acc_result_valid (acc_result_valid)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: pixels accepted so far, whether the frame has finished,
  // and the pixel event still in flight toward the accelerator.
  int         m_count    = 0;
  int         m_wait     = 0;
  bit         m_finished = 0;
  bit         m_overrun  = 0;
  bit         m_timeout  = 0;
  bit         m_prev     = 0;
  bit         m_pend     = 0;
  logic [7:0] m_pend_pix = '0;
  logic [31:0] m_buf [NUM_CH];
  bit         m_clr;
  bit         m_was_waiting;
  int         m_sel;
  logic        e_valid  = 1'b0;
  logic [7:0]  e_pixel  = '0;
  logic        e_clr_n  = 1'b0;
  logic [31:0] e_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_wait = 0; m_finished = 0; m_overrun = 0; m_timeout = 0;
      m_prev = 0; m_pend = 0;
      for (int k = 0; k < NUM_CH; k++) m_buf[k] = '0;
      e_valid = 0; e_pixel = '0; e_clr_n = 0; e_result = '0;
    end else begin
      m_clr         = pio_cmd[17];
      m_sel         = int'(pio_cmd[23:20]);
      e_result      = (m_sel < NUM_CH) ? m_buf[m_sel] : 32'd0;
      m_was_waiting = !m_finished && (m_count == FRAME);
      e_valid       = 0;
      e_clr_n       = !m_clr;
      if (m_clr) begin
        m_count = 0; m_wait = 0; m_finished = 0; m_overrun = 0; m_timeout = 0;
        for (int k = 0; k < NUM_CH; k++) m_buf[k] = '0;
      end else begin
        if (m_pend) begin
          if (!m_finished && m_count < FRAME) begin
            e_valid = 1; e_pixel = m_pend_pix; m_count++;
          end else begin
            m_overrun = 1;
          end
        end
        if (m_was_waiting) begin
          if (acc_result_valid) begin
            for (int k = 0; k < NUM_CH; k++) m_buf[k] = acc_result[k*32 +: 32];
            m_finished = 1;
          end else begin
            m_wait++;
            if (m_wait == TMO) begin m_timeout = 1; m_finished = 1; end
          end
        end
      end
      m_pend     = (pio_cmd[16] != m_prev) && !m_clr;
      m_pend_pix = pio_cmd[7:0];
      m_prev     = pio_cmd[16];
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[15:0]  = 16'(m_count);
    s[16]    = (m_count > 0) && !m_finished;
    s[17]    = m_finished;
    s[18]    = m_overrun;
    s[19]    = m_timeout;
    return s;
  endfunction

  always @(negedge clk) begin
    if (acc_valid === 1'b1) pulses++;
    if (chk_en) begin
      check("acc_valid", acc_valid, e_valid);
      check("acc_clr_n", acc_clr_n, e_clr_n);
      check("pio_status", pio_status, exp_status());
      check("pio_result", pio_result, e_result);
      if (e_valid) check("acc_pixel", acc_pixel, e_pixel);
    end
  end

  logic       tog_s = 1'b0;
  logic [3:0] sel_s = '0;

  task automatic drive(input logic clr, input logic [7:0] pix);
    pio_cmd = {8'($urandom), sel_s, 2'($urandom), clr, tog_s, 8'($urandom), pix};
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); drive(1'b0, 8'($urandom)); end
  endtask

  initial begin
    rst_n = 1'b0; pio_cmd = '0; acc_result = '0; acc_result_valid = 1'b0;
    #2 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_clr_n", acc_clr_n, 1'b0);
    check("reset_status", pio_status, 32'h0);
    check("reset_result", pio_result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_clr_n", acc_clr_n, 1'b1);
    check("release_status", pio_status, 32'h0);

    // Frame 1: random gaps, random selects and ignored result strobes.
    for (int i = 0; i < FRAME; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        sel_s = 4'($urandom);
        acc_result_valid = 1'($urandom);
        acc_result = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 8'($urandom));
      end
      if (i == 400) begin
        cycles(100);
        check("hold_pulses", 32'(pulses), 32'd400);
        check("hold_count", pio_status[15:0], 16'd400);
      end
      @(negedge clk);
      tog_s = ~tog_s;
      acc_result_valid = (i == FRAME - 1) ? 1'b0 : 1'($urandom);
      drive(1'b0, 8'(i % 256));
    end
    acc_result_valid = 1'b0;
    cycles(3);
    check("frame_pulses", 32'(pulses), 32'd784);
    check("frame_count", pio_status[15:0], 16'd784);
    check("frame_busy", pio_status[16], 1'b1);
    check("frame_not_done", pio_status[17], 1'b0);

    @(negedge clk);
    acc_result = {32'h44, 32'h33, 32'h22, 32'h11};
    acc_result_valid = 1'b1;
    sel_s = 4'd2;
    drive(1'b0, 8'h00);
    @(negedge clk);
    acc_result_valid = 1'b0;
    check("capture_done", pio_status[17:16], 2'b10);
    drive(1'b0, 8'h00);
    @(negedge clk);
    check("sel2_result", pio_result, 32'h33);
    sel_s = 4'd5; drive(1'b0, 8'h00);
    @(negedge clk);
    check("sel5_result", pio_result, 32'h0);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      sel_s = 4'(s);
      acc_result_valid = 1'($urandom);
      acc_result = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b0, 8'($urandom));
    end
    acc_result_valid = 1'b0;

    @(negedge clk); tog_s = ~tog_s; drive(1'b0, 8'hA5);
    cycles(3);
    check("overrun_flag", pio_status[18], 1'b1);
    check("overrun_no_pulse", 32'(pulses), 32'd784);

    // Soft clear coincident with a toggle: the toggle must be lost.
    @(negedge clk); tog_s = ~tog_s; drive(1'b1, 8'h5A);
    @(negedge clk);
    check("clear_status", pio_status, 32'h0);
    check("clear_clr_n", acc_clr_n, 1'b0);
    drive(1'b0, 8'h00);
    cycles(4);
    check("clear_no_pulse", 32'(pulses), 32'd784);
    check("clear_clr_n_rel", acc_clr_n, 1'b1);

    // Frame 2: back-to-back toggles, then no result -> timeout.
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk); tog_s = ~tog_s; sel_s = 4'($urandom); drive(1'b0, 8'($urandom));
    end
    for (int c = 0; c < TMO + 20 && pio_status[17] !== 1'b1; c++) cycles(1);
    check("timeout_flag", pio_status[19], 1'b1);
    check("timeout_done", pio_status[17], 1'b1);
    check("timeout_pulses", 32'(pulses), 32'd1568);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk); drive(1'b1, 8'h00);
    @(negedge clk); drive(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); tog_s = ~tog_s; drive(1'b0, 8'($urandom));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_status", pio_status, 32'h0);
    check("async_valid", acc_valid, 1'b0);
    check("async_clr_n", acc_clr_n, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    cycles(5);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
